serial_subtractor: RTL and testbench

//  Bit-serial multi-bit subtractor built around a single full-subtractor cell plus a borrow register.

---
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result valid-ready bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, LSB first, one full-subtractor cell.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int         c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic w_in_ready;
    logic w_out_valid;
    logic w_busy;
    logic w_ai;
    logic w_bi;
    logic w_d;
    logic w_bo;
    logic w_last;

    // Full-subtractor cell on the current LSBs
    assign w_ai   = r_a_sh[0];
    assign w_bi   = r_b_sh[0];
    assign w_d    = w_ai ^ w_bi ^ r_borrow;
    assign w_bo   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
    assign w_last = (r_cnt == c_CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.in_valid)  w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_last)        w_state_nxt = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_nxt = c_IDLE;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs decode from state only, so no input-to-handshake combinational path
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_IDLE:  w_in_ready  = 1'b1;
            c_SHIFT: w_busy      = 1'b1;
            c_DONE:  w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed minuend bit leaves at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                    end
                end
                c_SHIFT: begin
                    r_a_sh   <= {w_d, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff <= {w_d, r_a_sh[WIDTH-1:1]};
                        r_bout <= w_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed bench for serial_subtractor (WIDTH=8 and WIDTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) s8 ();
    serial_subtractor_if #(.WIDTH(3)) s3 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));
    serial_subtractor #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(s3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one word into the 8-bit DUT, waits for the result, then handshakes it.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ok, output int lat);
        int guard;
        s8.a = a; s8.b = b; s8.bin = bin; s8.in_valid = 1'b1; s8.out_ready = 1'b0;
        guard = 0;
        while (!s8.in_ready && guard < 100) begin tick(); guard++; end
        tick();
        s8.in_valid = 1'b0;
        lat = 0;
        while (!s8.out_valid && lat < 100) begin tick(); lat++; end
        ok = s8.out_valid; d = s8.diff; bo = s8.bout;
        s8.out_ready = 1'b1;
        tick();
        s8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++; if (s8.in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", s8.in_ready); end
        n_cmp++; if (s8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", s8.out_valid); end
        n_cmp++; if (s8.busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got=%b exp=0", s8.busy); end
        n_cmp++; if (s8.diff !== 8'h00)     begin n_err++; $display("FAIL rst_diff got=%h exp=00", s8.diff); end
        n_cmp++; if (s8.bout !== 1'b0)      begin n_err++; $display("FAIL rst_bout got=%b exp=0", s8.bout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] d; logic bo; logic ok; int lat;
        op8(8'h05, 8'h03, 1'b0, d, bo, ok, lat);
        n_cmp++; if (ok !== 1'b1)  begin n_err++; $display("FAIL basic_timeout got=%b exp=1", ok); end
        n_cmp++; if (lat != 8)     begin n_err++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        n_cmp++; if (d !== 8'h02)  begin n_err++; $display("FAIL basic_diff got=%h exp=02", d); end
        n_cmp++; if (bo !== 1'b0)  begin n_err++; $display("FAIL basic_bout got=%b exp=0", bo); end
    endtask

    task automatic test_borrow();
        logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h00, 8'hC8};
        logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h00, 8'h37};
        logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h91};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic bo; logic ok; int lat;
        for (int i = 0; i < 4; i++) begin
            op8(va[i], vb[i], vc[i], d, bo, ok, lat);
            n_cmp++;
            if (ok !== 1'b1 || d !== ed[i] || bo !== eb[i]) begin
                n_err++;
                $display("FAIL borrow_vec%0d got ok=%b diff=%h bout=%b exp ok=1 diff=%h bout=%b",
                         i, ok, d, bo, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        s8.a = 8'h20; s8.b = 8'h07; s8.bin = 1'b0; s8.in_valid = 1'b1; s8.out_ready = 1'b0;
        tick();
        s8.in_valid = 1'b0;
        guard = 0;
        while (!s8.out_valid && guard < 100) begin tick(); guard++; end
        // New word offered while the result is held back
        s8.a = 8'h10; s8.b = 8'h01; s8.bin = 1'b0; s8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (s8.out_valid !== 1'b1 || s8.diff !== 8'h19 || s8.bout !== 1'b0 || s8.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_c%0d got ov=%b diff=%h bout=%b ir=%b exp ov=1 diff=19 bout=0 ir=0",
                         i, s8.out_valid, s8.diff, s8.bout, s8.in_ready);
            end
            tick();
        end
        s8.out_ready = 1'b1;
        tick();
        s8.out_ready = 1'b0;
        n_cmp++;
        if (s8.in_ready !== 1'b1 || s8.out_valid !== 1'b0 || s8.diff !== 8'h19) begin
            n_err++;
            $display("FAIL bp_after_hs got ir=%b ov=%b diff=%h exp ir=1 ov=0 diff=19",
                     s8.in_ready, s8.out_valid, s8.diff);
        end
        tick();
        s8.in_valid = 1'b0;
        n_cmp++;
        if (s8.busy !== 1'b1 || s8.in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_accept got busy=%b ir=%b exp busy=1 ir=0", s8.busy, s8.in_ready);
        end
        guard = 0;
        while (!s8.out_valid && guard < 100) begin tick(); guard++; end
        n_cmp++;
        if (s8.out_valid !== 1'b1 || s8.diff !== 8'h0F || s8.bout !== 1'b0) begin
            n_err++;
            $display("FAIL bp_second got ov=%b diff=%h bout=%b exp ov=1 diff=0f bout=0",
                     s8.out_valid, s8.diff, s8.bout);
        end
        s8.out_ready = 1'b1;
        tick();
        s8.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] d; logic bo; logic ok; int lat;
        s8.a = 8'h5A; s8.b = 8'h3C; s8.bin = 1'b0; s8.in_valid = 1'b1;
        tick();
        s8.in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s8.out_valid !== 1'b0 || s8.in_ready !== 1'b1 || s8.diff !== 8'h00 || s8.bout !== 1'b0 || s8.busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async got ov=%b ir=%b diff=%h bout=%b busy=%b exp ov=0 ir=1 diff=00 bout=0 busy=0",
                     s8.out_valid, s8.in_ready, s8.diff, s8.bout, s8.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        op8(8'h5A, 8'h3C, 1'b0, d, bo, ok, lat);
        n_cmp++;
        if (ok !== 1'b1 || d !== 8'h1E || bo !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_recover got ok=%b diff=%h bout=%b exp ok=1 diff=1e bout=0", ok, d, bo);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h80, 8'h01, 8'h33};
        logic [7:0] vb [3] = '{8'h01, 8'h02, 8'h11};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ed [3] = '{8'h7F, 8'hFE, 8'h21};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        int acc_cyc [3];
        int idx, rcv;
        logic acc, hs;
        idx = 0; rcv = 0;
        s8.a = va[0]; s8.b = vb[0]; s8.bin = vc[0]; s8.in_valid = 1'b1; s8.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && rcv < 3; cyc++) begin
            acc = s8.in_valid & s8.in_ready;
            hs  = s8.out_valid & s8.out_ready;
            if (hs) begin
                n_cmp++;
                if (s8.diff !== ed[rcv] || s8.bout !== eb[rcv]) begin
                    n_err++;
                    $display("FAIL b2b_word%0d got diff=%h bout=%b exp diff=%h bout=%b",
                             rcv, s8.diff, s8.bout, ed[rcv], eb[rcv]);
                end
                rcv++;
            end
            tick();
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    s8.a = va[idx]; s8.b = vb[idx]; s8.bin = vc[idx];
                end else begin
                    s8.in_valid = 1'b0;
                end
            end
        end
        s8.out_ready = 1'b0;
        s8.in_valid  = 1'b0;
        n_cmp++;
        if (rcv != 3 || idx != 3) begin
            n_err++; $display("FAIL b2b_count got rcv=%0d acc=%0d exp 3/3", rcv, idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
                    n_err++;
                    $display("FAIL b2b_period%0d got=%0d exp=10", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_exhaustive_w3();
        int guard, r;
        logic [2:0] exp_d;
        logic       exp_b;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    r     = a - b - c;
                    exp_d = 3'(r & 7);
                    exp_b = (r < 0);
                    s3.a = 3'(a); s3.b = 3'(b); s3.bin = c[0]; s3.in_valid = 1'b1; s3.out_ready = 1'b0;
                    guard = 0;
                    while (!s3.in_ready && guard < 20) begin tick(); guard++; end
                    tick();
                    s3.in_valid = 1'b0;
                    guard = 0;
                    while (!s3.out_valid && guard < 20) begin tick(); guard++; end
                    n_cmp++;
                    if (s3.out_valid !== 1'b1 || s3.diff !== exp_d || s3.bout !== exp_b) begin
                        n_err++;
                        $display("FAIL w3_a%0d_b%0d_bin%0d got ov=%b diff=%0d bout=%b exp ov=1 diff=%0d bout=%b",
                                 a, b, c, s3.out_valid, s3.diff, s3.bout, exp_d, exp_b);
                    end
                    s3.out_ready = 1'b1;
                    tick();
                    s3.out_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        s8.in_valid = 1'b0; s8.a = '0; s8.b = '0; s8.bin = 1'b0; s8.out_ready = 1'b0;
        s3.in_valid = 1'b0; s3.a = '0; s3.b = '0; s3.bin = 1'b0; s3.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_exhaustive_w3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
